// File: rtl/uart_cal_ctrl.sv
// rtl/uart_cal_ctrl.sv - UART command sequencer: parses "A op B =", computes, replies in ASCII decimal
`timescale 1ns/1ps
module uart_cal_ctrl #(
    parameter int MAXD = 3,
    parameter int RW   = 21
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    input  logic          tx_busy_i,
    output logic [7:0]    tx_data_o,
    output logic          tx_valid_o,
    output logic          busy_o,
    output logic [RW-1:0] result_o,
    output logic          result_valid_o,
    output logic          err_o
);

    // Operand accumulators hold 0..999; digit counters only need to reach MAXD.
    localparam int AW = 10;
    localparam int CW = $clog2(MAXD + 1);
    localparam logic [CW-1:0] MAXD_C = CW'(MAXD);
    localparam int NBUF = 9;

    typedef enum logic [2:0] {
        S_GET_A,
        S_GET_B,
        S_CALC,
        S_CONV,
        S_SEND,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_t;

    // Per-byte transmit handshake: issue strobe, blind guard cycle, wait for idle.
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_GUARD,
        PH_WAIT
    } ph_t;

    state_t          state_q;
    op_t             op_q;
    ph_t             ph_q;
    logic [AW-1:0]   a_q;
    logic [AW-1:0]   b_q;
    logic [CW-1:0]   cnta_q;
    logic [CW-1:0]   cntb_q;
    logic [RW-1:0]   mag_q;
    logic [2:0]      pidx_q;
    logic [3:0]      dig_q;
    logic            started_q;
    logic [3:0]      widx_q;
    logic [3:0]      sidx_q;
    logic [3:0]      len_q;
    logic [7:0]      obuf_q [NBUF];

    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            busy_q;
    logic [RW-1:0]   result_q;
    logic            result_valid_q;
    logic            err_q;

    logic            is_digit_d;
    logic            is_space_d;
    logic            is_op_d;
    logic            is_eq_d;
    op_t             op_sel_d;
    logic [AW-1:0]   digit_d;
    logic [AW-1:0]   a_acc_d;
    logic [AW-1:0]   b_acc_d;
    logic [RW-1:0]   a_ext_d;
    logic [RW-1:0]   b_ext_d;
    logic [RW-1:0]   calc_d;
    logic            calc_neg_d;
    logic [RW-1:0]   calc_mag_d;
    logic [RW-1:0]   pow_d;
    logic            conv_ge_d;
    logic            conv_emit_d;
    logic [7:0]      digit_chr_d;

    // Classify the incoming byte and precompute the decimal accumulate step.
    always_comb begin
        is_digit_d = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
        is_space_d = (rx_data_i == 8'h20);
        is_eq_d    = (rx_data_i == 8'h3D);
        is_op_d    = 1'b0;
        op_sel_d   = OP_ADD;
        case (rx_data_i)
            8'h2B: begin is_op_d = 1'b1; op_sel_d = OP_ADD; end
            8'h2D: begin is_op_d = 1'b1; op_sel_d = OP_SUB; end
            8'h2A: begin is_op_d = 1'b1; op_sel_d = OP_MUL; end
            default: begin is_op_d = 1'b0; op_sel_d = OP_ADD; end
        endcase
        digit_d = {{(AW-4){1'b0}}, rx_data_i[3:0]};
        a_acc_d = (a_q << 3) + (a_q << 1) + digit_d;
        b_acc_d = (b_q << 3) + (b_q << 1) + digit_d;
    end

    // Signed arithmetic on zero-extended operands; the product of two 3-digit values fits in RW bits.
    always_comb begin
        a_ext_d = {{(RW-AW){1'b0}}, a_q};
        b_ext_d = {{(RW-AW){1'b0}}, b_q};
        case (op_q)
            OP_ADD:  calc_d = a_ext_d + b_ext_d;
            OP_SUB:  calc_d = a_ext_d - b_ext_d;
            OP_MUL:  calc_d = a_ext_d * b_ext_d;
            default: calc_d = '0;
        endcase
        calc_neg_d = calc_d[RW-1];
        calc_mag_d = calc_neg_d ? (~calc_d + 1'b1) : calc_d;
    end

    // Decimal conversion helpers: current power of ten, subtract test, digit emission rule.
    always_comb begin
        case (pidx_q)
            3'd0:    pow_d = RW'(100000);
            3'd1:    pow_d = RW'(10000);
            3'd2:    pow_d = RW'(1000);
            3'd3:    pow_d = RW'(100);
            3'd4:    pow_d = RW'(10);
            default: pow_d = RW'(1);
        endcase
        conv_ge_d   = (mag_q >= pow_d);
        conv_emit_d = (dig_q != 4'd0) || started_q || (pidx_q == 3'd5);
        digit_chr_d = 8'h30 + {4'b0000, dig_q};
    end

    // Main sequencer: parse, compute, convert, transmit, with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_GET_A;
            op_q           <= OP_ADD;
            ph_q           <= PH_ISSUE;
            a_q            <= '0;
            b_q            <= '0;
            cnta_q         <= '0;
            cntb_q         <= '0;
            mag_q          <= '0;
            pidx_q         <= '0;
            dig_q          <= '0;
            started_q      <= 1'b0;
            widx_q         <= '0;
            sidx_q         <= '0;
            len_q          <= '0;
            for (int i = 0; i < NBUF; i++) obuf_q[i] <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            tx_valid_q     <= 1'b0;
            result_valid_q <= 1'b0;
            case (state_q)
                S_GET_A: begin
                    if (rx_valid_i) begin
                        if (is_digit_d) begin
                            if (cnta_q == MAXD_C) begin
                                state_q <= S_ERR;
                                busy_q  <= 1'b1;
                            end else begin
                                a_q    <= a_acc_d;
                                cnta_q <= cnta_q + 1'b1;
                            end
                        end else if (is_op_d && (cnta_q != '0)) begin
                            op_q    <= op_sel_d;
                            state_q <= S_GET_B;
                        end else if (!is_space_d) begin
                            state_q <= S_ERR;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_GET_B: begin
                    if (rx_valid_i) begin
                        if (is_digit_d) begin
                            if (cntb_q == MAXD_C) begin
                                state_q <= S_ERR;
                                busy_q  <= 1'b1;
                            end else begin
                                b_q    <= b_acc_d;
                                cntb_q <= cntb_q + 1'b1;
                            end
                        end else if (is_eq_d && (cntb_q != '0)) begin
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                        end else if (!is_space_d) begin
                            state_q <= S_ERR;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    result_q       <= calc_d;
                    result_valid_q <= 1'b1;
                    err_q          <= 1'b0;
                    mag_q          <= calc_mag_d;
                    pidx_q         <= '0;
                    dig_q          <= '0;
                    started_q      <= 1'b0;
                    if (calc_neg_d) begin
                        obuf_q[0] <= 8'h2D;
                        widx_q    <= 4'd1;
                    end else begin
                        widx_q    <= 4'd0;
                    end
                    state_q <= S_CONV;
                end
                S_CONV: begin
                    if (conv_ge_d) begin
                        mag_q <= mag_q - pow_d;
                        dig_q <= dig_q + 4'd1;
                    end else begin
                        dig_q <= 4'd0;
                        if (conv_emit_d) begin
                            obuf_q[widx_q] <= digit_chr_d;
                            widx_q         <= widx_q + 4'd1;
                            started_q      <= 1'b1;
                        end
                        if (pidx_q == 3'd5) begin
                            // Units digit is always emitted, so CR LF follow it directly.
                            obuf_q[widx_q + 4'd1] <= 8'h0D;
                            obuf_q[widx_q + 4'd2] <= 8'h0A;
                            len_q                 <= widx_q + 4'd3;
                            sidx_q                <= '0;
                            ph_q                  <= PH_ISSUE;
                            state_q               <= S_SEND;
                        end else begin
                            pidx_q <= pidx_q + 3'd1;
                        end
                    end
                end
                S_SEND: begin
                    case (ph_q)
                        PH_ISSUE: begin
                            if (!tx_busy_i) begin
                                tx_data_q  <= obuf_q[sidx_q];
                                tx_valid_q <= 1'b1;
                                ph_q       <= PH_GUARD;
                            end
                        end
                        PH_GUARD: begin
                            // Transmitter raises busy only a cycle later; do not trust it yet.
                            ph_q <= PH_WAIT;
                        end
                        default: begin
                            if (!tx_busy_i) begin
                                if (sidx_q == (len_q - 4'd1)) begin
                                    a_q     <= '0;
                                    b_q     <= '0;
                                    cnta_q  <= '0;
                                    cntb_q  <= '0;
                                    busy_q  <= 1'b0;
                                    ph_q    <= PH_ISSUE;
                                    state_q <= S_GET_A;
                                end else begin
                                    sidx_q <= sidx_q + 4'd1;
                                    ph_q   <= PH_ISSUE;
                                end
                            end
                        end
                    endcase
                end
                S_ERR: begin
                    err_q     <= 1'b1;
                    obuf_q[0] <= 8'h45;
                    obuf_q[1] <= 8'h0D;
                    obuf_q[2] <= 8'h0A;
                    len_q     <= 4'd3;
                    sidx_q    <= '0;
                    ph_q      <= PH_ISSUE;
                    state_q   <= S_SEND;
                end
                default: begin
                    state_q <= S_GET_A;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data_o      = tx_data_q;
    assign tx_valid_o     = tx_valid_q;
    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_uart_cal_ctrl.sv
// tb/tb_uart_cal_ctrl.sv - directed self-checking bench for uart_cal_ctrl
`timescale 1ns/1ps
module tb_uart_cal_ctrl;

    localparam int RW    = 21;
    localparam int FRAME = 150;
    localparam int LIMIT = 20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          tx_busy = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          err;

    int  n_checks = 0;
    int  n_pass   = 0;
    byte tx_q[$];
    int  rv_cnt    = 0;
    int  viol      = 0;
    int  frame_cnt = 0;
    logic pend      = 1'b0;
    logic hold_busy = 1'b0;

    uart_cal_ctrl #(.MAXD(3), .RW(RW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .tx_busy_i      (tx_busy),
        .tx_data_o      (tx_data),
        .tx_valid_o     (tx_valid),
        .busy_o         (busy),
        .result_o       (result),
        .result_valid_o (result_valid),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    // UART transmitter model: busy from the cycle after the strobe for FRAME cycles.
    always @(negedge clk) begin
        if (tx_valid && (tx_busy || pend)) viol++;
        if (result_valid) rv_cnt++;
        if (pend) begin
            frame_cnt = FRAME;
            pend = 1'b0;
        end else if (frame_cnt > 0) begin
            frame_cnt--;
        end
        if (tx_valid) begin
            tx_q.push_back(tx_data);
            pend = 1'b1;
        end
        tx_busy = (frame_cnt > 0) || hold_busy;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic run_expr(input string name, input string s, input string exp);
        int base;
        int cyc;
        base = tx_q.size();
        send_str(s);
        cyc = 0;
        while ((tx_q.size() - base < exp.len()) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        while (busy && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (cyc >= LIMIT) $display("FAIL %s timeout got %0d cycles limit %0d", name, cyc, LIMIT);
        else n_pass++;
        n_checks++;
        if (tx_q.size() - base !== exp.len())
            $display("FAIL %s byte count got %0d exp %0d", name, tx_q.size() - base, exp.len());
        else n_pass++;
        for (int i = 0; i < exp.len(); i++) begin
            n_checks++;
            if (base + i >= tx_q.size())
                $display("FAIL %s byte%0d missing exp 0x%02h", name, i, exp[i]);
            else if (tx_q[base + i] !== exp[i])
                $display("FAIL %s byte%0d got 0x%02h exp 0x%02h", name, i, tx_q[base + i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (tx_valid !== 1'b0) $display("FAIL reset tx_valid got %0b exp 0", tx_valid); else n_pass++;
        n_checks++;
        if (tx_data !== 8'h00) $display("FAIL reset tx_data got 0x%02h exp 0x00", tx_data); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset busy got %0b exp 0", busy); else n_pass++;
        n_checks++;
        if (result !== '0) $display("FAIL reset result got %0d exp 0", result); else n_pass++;
        n_checks++;
        if (result_valid !== 1'b0) $display("FAIL reset result_valid got %0b exp 0", result_valid); else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL reset err got %0b exp 0", err); else n_pass++;
    endtask

    task automatic test_add();
        int rvb;
        rvb = rv_cnt;
        run_expr("add", "12+34=", "46\r\n");
        n_checks++;
        if (result !== 21'd46) $display("FAIL add result got %0d exp 46", result); else n_pass++;
        n_checks++;
        if (rv_cnt - rvb !== 1) $display("FAIL add result_valid pulses got %0d exp 1", rv_cnt - rvb); else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL add err got %0b exp 0", err); else n_pass++;
    endtask

    task automatic test_sub();
        run_expr("sub", "5-9=", "-4\r\n");
        n_checks++;
        if (result !== 21'h1FFFFC) $display("FAIL sub result got 0x%06h exp 0x1FFFFC", result); else n_pass++;
    endtask

    task automatic test_mul();
        run_expr("mul_max", "999*999=", "998001\r\n");
        n_checks++;
        if (result !== 21'd998001) $display("FAIL mul_max result got %0d exp 998001", result); else n_pass++;
        run_expr("mul_zero", "0 * 7 =", "0\r\n");
        n_checks++;
        if (result !== 21'd0) $display("FAIL mul_zero result got %0d exp 0", result); else n_pass++;
    endtask

    task automatic test_parse_err();
        int rvb;
        rvb = rv_cnt;
        run_expr("bad_op", "1x2=", "E\r\n");
        n_checks++;
        if (err !== 1'b1) $display("FAIL bad_op err got %0b exp 1", err); else n_pass++;
        n_checks++;
        if (rv_cnt - rvb !== 0) $display("FAIL bad_op result_valid pulses got %0d exp 0", rv_cnt - rvb); else n_pass++;
        n_checks++;
        if (result !== 21'd0) $display("FAIL bad_op result got %0d exp 0", result); else n_pass++;
        run_expr("recover", "1+1=", "2\r\n");
        n_checks++;
        if (err !== 1'b0) $display("FAIL recover err got %0b exp 0", err); else n_pass++;
        n_checks++;
        if (result !== 21'd2) $display("FAIL recover result got %0d exp 2", result); else n_pass++;
    endtask

    task automatic test_overlong_hold();
        int base;
        int cyc;
        base = tx_q.size();
        hold_busy = 1'b1;
        send_str("1234+1=");
        repeat (300) @(negedge clk);
        n_checks++;
        if (tx_q.size() !== base) $display("FAIL hold tx bytes got %0d exp 0", tx_q.size() - base); else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL hold busy got %0b exp 1", busy); else n_pass++;
        n_checks++;
        if (err !== 1'b1) $display("FAIL hold err got %0b exp 1", err); else n_pass++;
        hold_busy = 1'b0;
        cyc = 0;
        while ((tx_q.size() - base < 3 || busy) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (tx_q.size() - base !== 3) $display("FAIL overlong byte count got %0d exp 3", tx_q.size() - base); else n_pass++;
        n_checks++;
        if (tx_q.size() >= base + 3 && !(tx_q[base] === 8'h45 && tx_q[base+1] === 8'h0D && tx_q[base+2] === 8'h0A))
            $display("FAIL overlong bytes got %02h %02h %02h exp 45 0d 0a", tx_q[base], tx_q[base+1], tx_q[base+2]);
        else if (tx_q.size() < base + 3) $display("FAIL overlong bytes missing got %0d exp 3", tx_q.size() - base);
        else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        int base;
        int cyc;
        base = tx_q.size();
        send_str("12+34=");
        cyc = 0;
        while (tx_q.size() == base && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (tx_q.size() !== base + 1 || tx_q[base] !== 8'h34)
            $display("FAIL rst_mid first byte got count %0d exp 1 byte 0x34", tx_q.size() - base);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0)
            $display("FAIL rst_mid strobes got tx_valid=%0b busy=%0b rv=%0b exp 0", tx_valid, busy, result_valid);
        else n_pass++;
        n_checks++;
        if (result !== '0 || err !== 1'b0 || tx_data !== 8'h00)
            $display("FAIL rst_mid values got result=%0d err=%0b tx_data=0x%02h exp 0", result, err, tx_data);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (tx_busy && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        repeat (50) @(negedge clk);
        n_checks++;
        if (tx_q.size() !== base + 1) $display("FAIL rst_mid extra bytes got %0d exp 0", tx_q.size() - base - 1); else n_pass++;
        run_expr("after_rst", "7+0=", "7\r\n");
        n_checks++;
        if (result !== 21'd7) $display("FAIL after_rst result got %0d exp 7", result); else n_pass++;
    endtask

    task automatic test_protocol();
        n_checks++;
        if (viol !== 0) $display("FAIL protocol tx_valid during busy/guard got %0d exp 0", viol); else n_pass++;
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_parse_err();
        test_overlong_hold();
        test_reset_mid_send();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cal_ctrl.md
Name: uart_cal_ctrl

Overview:
- Command sequencer between the UART (rx_data/rx_valid in, tx_data/tx_valid out) and the calculator datapath.
- Parses ASCII expressions of the form "A op B =" from the RX byte stream and computes the result.
- Returns the result as ASCII decimal followed by CR LF through the UART transmitter, one byte per TX handshake.
- Any malformed input is answered with "E\r\n" and the parser restarts.

Parameters:
MAXD, 3, max decimal digits per operand (operands 0..999)
RW, 21, signed result width (covers -999..998001)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_data  in  8  received byte from uart
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_busy  in  1  uart transmitter busy; high from cycle after tx_valid until stop bit done
tx_data  out  8  byte to transmit
tx_valid  out  1  one-cycle transmit strobe
busy  out  1  high in CALC/CONV/SEND/ERR
result  out  RW  signed result of last successful expression
result_valid  out  1  one-cycle pulse when result updates
err  out  1  sticky error flag; set on parse error, cleared by next successful '='

Behaviour:
- Reset (async, rst=1): state=GET_A, accumulators and digit counts =0, tx_data=0, tx_valid=0, busy=0, result=0, result_valid=0, err=0. Reset mid-transmission aborts immediately; no further tx_valid.
- Byte 0x20 (space) is ignored in GET_A, GET_B and OP_WAIT.
- Bytes arriving while busy=1 are dropped silently.
- GET_A:
  - digit '0'..'9': a = a*10 + d, cnta++.
  - '+', '-', '*' with cnta>=1: latch op -> GET_B.
  - Anything else, or a digit when cnta==MAXD -> ERR.
- GET_B: digit -> b accumulate, same limit. '=' with cntb>=1 -> CALC. Anything else -> ERR.
- CALC (1 cycle):
  - result = a+b, a-b or a*b, signed, RW bits; no overflow possible with MAXD=3.
  - Pulse result_valid; clear err -> CONV.
- CONV:
  - If negative, queue '-' and use the magnitude.
  - Repeated subtraction against powers 100000, 10000, 1000, 100, 10, 1; at most one subtraction per cycle.
  - Leading zeros suppressed; zero result yields a single '0'.
  - Digits written to a 9-entry byte buffer (sign + 6 digits + 0x0D + 0x0A).
  - Worst-case latency <= 6*10 cycles -> SEND.
- SEND: handshake per byte:
  - When tx_busy=0 and no send pending, drive tx_data=buf[i] and pulse tx_valid for exactly one cycle.
  - Next cycle is a guard cycle (tx_busy ignored).
  - Then wait for tx_busy=0 and advance i.
  - After the last byte (0x0A) completes, clear accumulators -> GET_A.
- ERR: set err=1; load buffer "E", 0x0D, 0x0A; proceed as SEND; then GET_A with cleared accumulators.
- tx_data holds its last value between strobes.
- tx_valid is never asserted while tx_busy=1 or in the guard cycle.
- Simultaneous rx_valid and state exit: the byte belongs to the state it arrived in.

Test Plan:
- "12+34=" bytes, tx_busy model 150-cycle frames -> tx bytes 0x34,0x36,0x0D,0x0A; result=46, result_valid one pulse.
- "5-9=" -> 0x2D,0x34,0x0D,0x0A; result=-4 (0x1FFFFC).
- "999*999=" -> "998001\r\n" (0x39,0x39,0x38,0x30,0x30,0x31,0x0D,0x0A); result=998001. Also "0*7=" -> "0\r\n".
- "1x2=" -> "E\r\n" (0x45,0x0D,0x0A), err=1. Then "1+1=" -> "2\r\n", err=0.
- "1234+1=": 4th digit -> ERR, "E\r\n". Bytes received during busy are dropped; hold tx_busy high and check no tx_valid until it falls.
- Assert rst for 3 cycles during SEND of "46": tx_valid=0 immediately, all outputs at reset values. Then "7+0=" -> "7\r\n".
